// File: rtl/carwash_pkg.sv
// Shared types and default constants for the wash-bay scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package carwash_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_TOK1 = 3'd2,
        S_TOK2 = 3'd3,
        S_STRT = 3'd4,
        S_RUN  = 3'd5,
        S_DONE = 3'd6
    } sched_state_t;

    localparam int T1_DEFAULT = 8;   // spray timer expiry count
    localparam int T2_DEFAULT = 4;   // rinse timer expiry count
    localparam int WD_DEFAULT = 64;  // RUN-state watchdog limit

endpackage

// File: rtl/carwash_timer.sv
// Saturating up-counter with synchronous clear and a registered expiry flag.
// Latency: clear in cycle c -> done rises in cycle c+LIMIT+1, holds until the next clear.
// Backpressure: none; counts every cycle, clear wins over increment.
// Ports: clk, CLR (async active-low reset), clr_t (load 0), done (count reached LIMIT).
module carwash_timer #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic CLR,
    input  logic clr_t,
    output logic done
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clr_t) begin
            count_nxt = '0;
        end else if (count != LIM) begin
            count_nxt = count + CW'(1);
        end
    end

    // done is registered from the next count so it lines up with the count itself.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_nxt;
            done  <= (count_nxt == LIM);
        end
    end

endmodule

// File: rtl/carwash_bay_scheduler.sv
// Round-robin sharing of one wash bay among pay kiosks; replays the purchase as TOKEN/START pulses.
// Latency: request -> first TOKEN 2 cycles; done one cycle after the final SPRAY fall is seen.
// Backpressure: requests are ignored from grant until back in IDLE; losers keep requesting.
// Ports: kiosk_req/kiosk_deluxe in, grant out; TOKEN/START to the controller; CLRT1/CLRT2 in,
//        T1DONE/T2DONE out; SPRAY/SOAP monitored; busy/done/active_id/fault/wash_abort status.
module carwash_bay_scheduler
    import carwash_pkg::*;
#(
    parameter int N_KIOSK   = 2,
    parameter int T1_CYCLES = T1_DEFAULT,
    parameter int T2_CYCLES = T2_DEFAULT,
    parameter int WD_CYCLES = WD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       CLR,
    input  logic [N_KIOSK-1:0]         kiosk_req,
    input  logic [N_KIOSK-1:0]         kiosk_deluxe,
    output logic [N_KIOSK-1:0]         grant,
    output logic                       TOKEN,
    output logic                       START,
    input  logic                       CLRT1,
    input  logic                       CLRT2,
    input  logic                       SPRAY,
    input  logic                       SOAP,
    output logic                       T1DONE,
    output logic                       T2DONE,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_KIOSK)-1:0] active_id,
    output logic                       fault,
    output logic                       wash_abort
);

    localparam int ID_W = $clog2(N_KIOSK);
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    sched_state_t    state;
    sched_state_t    state_nxt;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] id_inc;
    logic            win_vld;
    logic            deluxe_q;
    logic            spray_q;
    logic [1:0]      fall_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            spray_fall;
    logic            wash_complete;
    logic            wd_expire;

    // SOAP is observed by the controller only; kept visible here for probing.
    logic            unused_soap;
    assign unused_soap = SOAP;

    function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= N_KIOSK) begin
            s = s - N_KIOSK;
        end
        return ID_W'(s);
    endfunction

    // Scan from rr_ptr upward with wrap; the first requesting kiosk wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = 0; i < N_KIOSK; i++) begin
            cand = wrap_idx(int'(rr_ptr), i);
            if (!win_vld && kiosk_req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign id_inc        = (active_id == ID_W'(N_KIOSK - 1)) ? '0 : active_id + ID_W'(1);
    assign spray_fall    = spray_q & ~SPRAY;
    // Basic washes need one spray burst, deluxe washes two.
    assign wash_complete = spray_fall && ((fall_cnt + 2'd1) == (deluxe_q ? 2'd2 : 2'd1));
    // wd_cnt holds the number of RUN cycles already spent, so this is the last allowed one.
    assign wd_expire     = (wd_cnt == WD_W'(WD_CYCLES - 1));

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (|kiosk_req) state_nxt = S_ARB;
            S_ARB:  state_nxt = win_vld ? S_TOK1 : S_IDLE;
            S_TOK1: state_nxt = deluxe_q ? S_TOK2 : S_STRT;
            S_TOK2: state_nxt = S_RUN;
            S_STRT: state_nxt = S_RUN;
            S_RUN: begin
                if (wash_complete) begin
                    state_nxt = S_DONE;
                end else if (wd_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        grant      = '0;
        TOKEN      = 1'b0;
        START      = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        fault      = 1'b0;
        wash_abort = 1'b0;
        case (state)
            S_ARB:  if (win_vld) grant[win_id] = 1'b1;
            S_TOK1: TOKEN = 1'b1;
            S_TOK2: TOKEN = 1'b1;
            S_STRT: START = 1'b1;
            S_RUN: begin
                // A completing burst on the last watchdog cycle still counts as a wash.
                fault      = wd_expire && !wash_complete;
                wash_abort = wd_expire && !wash_complete;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // ---- datapath registers ----
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            rr_ptr    <= '0;
            active_id <= '0;
            deluxe_q  <= 1'b0;
            spray_q   <= 1'b0;
            fall_cnt  <= '0;
            wd_cnt    <= '0;
        end else begin
            spray_q <= SPRAY;
            if (state == S_ARB && win_vld) begin
                active_id <= win_id;
                deluxe_q  <= kiosk_deluxe[win_id];
            end
            if (state == S_RUN) begin
                if (!wd_expire) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
                if (spray_fall) begin
                    fall_cnt <= fall_cnt + 2'd1;
                end
            end else begin
                wd_cnt   <= '0;
                fall_cnt <= '0;
            end
            // Aborted washes advance the pointer too, so a stuck kiosk cannot hog the bay.
            if (state == S_DONE || fault) begin
                rr_ptr <= id_inc;
            end
        end
    end

    carwash_timer #(.LIMIT(T1_CYCLES)) u_t1 (
        .clk   (clk),
        .CLR   (CLR),
        .clr_t (CLRT1),
        .done  (T1DONE)
    );

    carwash_timer #(.LIMIT(T2_CYCLES)) u_t2 (
        .clk   (clk),
        .CLR   (CLR),
        .clr_t (CLRT2),
        .done  (T2DONE)
    );

endmodule

// File: tb/tb_carwash_bay_scheduler.sv
// Directed bench for carwash_bay_scheduler: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_carwash_bay_scheduler;

    logic       clk = 1'b0;
    logic       CLR = 1'b0;
    logic [1:0] kiosk_req = '0;
    logic [1:0] kiosk_deluxe = '0;
    logic [1:0] grant;
    logic       TOKEN, START;
    logic       CLRT1 = 1'b1;
    logic       CLRT2 = 1'b1;
    logic       SPRAY = 1'b0;
    logic       SOAP = 1'b0;
    logic       T1DONE, T2DONE;
    logic       busy, done;
    logic [0:0] active_id;
    logic       fault, wash_abort;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    carwash_bay_scheduler #(
        .N_KIOSK   (2),
        .T1_CYCLES (8),
        .T2_CYCLES (4),
        .WD_CYCLES (64)
    ) dut (
        .clk          (clk),
        .CLR          (CLR),
        .kiosk_req    (kiosk_req),
        .kiosk_deluxe (kiosk_deluxe),
        .grant        (grant),
        .TOKEN        (TOKEN),
        .START        (START),
        .CLRT1        (CLRT1),
        .CLRT2        (CLRT2),
        .SPRAY        (SPRAY),
        .SOAP         (SOAP),
        .T1DONE       (T1DONE),
        .T2DONE       (T2DONE),
        .busy         (busy),
        .done         (done),
        .active_id    (active_id),
        .fault        (fault),
        .wash_abort   (wash_abort)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] dlx;
        logic       spray;
        logic [1:0] grant;
        logic       token;
        logic       start;
        logic       busy;
        logic       done;
        logic       aid;
    } vec_t;

    vec_t vt[32];
    int   nv = 0;

    task automatic add(input logic rst, input logic [1:0] req, input logic [1:0] dlx,
                       input logic spray, input logic [1:0] g, input logic tok,
                       input logic st, input logic b, input logic d, input logic aid);
        vt[nv].rst   = rst;
        vt[nv].req   = req;
        vt[nv].dlx   = dlx;
        vt[nv].spray = spray;
        vt[nv].grant = g;
        vt[nv].token = tok;
        vt[nv].start = st;
        vt[nv].busy  = b;
        vt[nv].done  = d;
        vt[nv].aid   = aid;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        CLR = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        CLR = 1'b1;
    endtask

    // Drives a basic wash from IDLE to its first RUN cycle; returns at the RUN cycle.
    task automatic start_basic(input logic [1:0] req);
        kiosk_req    = req;
        kiosk_deluxe = 2'b00;
        SPRAY        = 1'b0;
        tick();              // IDLE -> ARB
        tick();              // ARB -> TOK1
        kiosk_req = 2'b00;
        tick();              // TOK1 -> STRT
        SPRAY = 1'b1;
        tick();              // STRT -> RUN
    endtask

    initial begin
        // Basic wash, kiosk 0.
        add(1, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b01, 2'b00, 0, 2'b01, 0, 0, 1, 0, 0);
        add(0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 1, 0, 0);
        add(0, 2'b00, 2'b00, 0, 2'b00, 0, 1, 1, 0, 0);
        add(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 0, 0);
        add(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 1, 0, 0);
        add(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 0, 0);
        add(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 1, 0);
        add(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
        // Both kiosks held, kiosk 1 deluxe: kiosk 0 first, then kiosk 1 with two tokens.
        add(1, 2'b11, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b11, 2'b10, 0, 2'b01, 0, 0, 1, 0, 0);
        add(0, 2'b11, 2'b10, 0, 2'b00, 1, 0, 1, 0, 0);
        add(0, 2'b11, 2'b10, 0, 2'b00, 0, 1, 1, 0, 0);
        add(0, 2'b11, 2'b10, 1, 2'b00, 0, 0, 1, 0, 0);
        add(0, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 0, 0);
        add(0, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 1, 0);
        add(0, 2'b11, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b11, 2'b10, 0, 2'b10, 0, 0, 1, 0, 0);
        add(0, 2'b11, 2'b10, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 2'b11, 2'b10, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 2'b11, 2'b10, 1, 2'b00, 0, 0, 1, 0, 1);
        add(0, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 2'b11, 2'b10, 1, 2'b00, 0, 0, 1, 0, 1);
        add(0, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 2'b11, 2'b10, 0, 2'b00, 0, 0, 1, 1, 1);
        add(0, 2'b00, 2'b10, 0, 2'b00, 0, 0, 0, 0, 1);

        // ---- reset release, idle for 20 cycles ----
        do_reset();
        for (int c = 0; c < 20; c++) begin
            #2;
            chk("idle_outputs",
                {grant, TOKEN, START, busy, done, fault, wash_abort, T1DONE, T2DONE, active_id},
                '0);
            tick();
        end

        // ---- table-driven sequences ----
        for (int i = 0; i < nv; i++) begin
            if (vt[i].rst) begin
                kiosk_req = '0;
                SPRAY     = 1'b0;
                do_reset();
            end
            kiosk_req    = vt[i].req;
            kiosk_deluxe = vt[i].dlx;
            SPRAY        = vt[i].spray;
            #2;
            chk($sformatf("vec%0d_grant", i), grant, vt[i].grant);
            chk($sformatf("vec%0d_token", i), TOKEN, vt[i].token);
            chk($sformatf("vec%0d_start", i), START, vt[i].start);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("vec%0d_done", i), done, vt[i].done);
            chk($sformatf("vec%0d_aid", i), active_id, vt[i].aid);
            chk($sformatf("vec%0d_fault", i), {fault, wash_abort}, 2'b00);
            tick();
        end

        // ---- timer expiry and clear ----
        kiosk_req = '0;
        SPRAY     = 1'b0;
        CLRT1     = 1'b0;
        CLRT2     = 1'b0;
        repeat (12) tick();
        #2;
        chk("t1_saturated", T1DONE, 1'b1);
        chk("t2_saturated", T2DONE, 1'b1);
        CLRT1 = 1'b1;
        CLRT2 = 1'b1;
        tick();                          // clear cycle c sampled
        CLRT1 = 1'b0;
        CLRT2 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            #2;
            chk($sformatf("t1_c+%0d", k), T1DONE, (k == 9) ? 1'b1 : 1'b0);
            chk($sformatf("t2_c+%0d", k), T2DONE, (k >= 5) ? 1'b1 : 1'b0);
            if (k < 9) tick();
        end
        CLRT1 = 1'b1;                    // clear right at expiry
        tick();
        CLRT1 = 1'b0;
        #2;
        chk("t1_drop_after_clear", T1DONE, 1'b0);
        chk("t2_holds", T2DONE, 1'b1);
        tick();
        CLRT1 = 1'b1;
        CLRT2 = 1'b1;

        // ---- watchdog: SPRAY never falls ----
        do_reset();
        start_basic(2'b01);
        for (int k = 1; k <= 64; k++) begin
            #2;
            chk($sformatf("wd_fault_run%0d", k), {fault, wash_abort}, (k == 64) ? 2'b11 : 2'b00);
            chk($sformatf("wd_busy_run%0d", k), busy, 1'b1);
            chk($sformatf("wd_done_run%0d", k), done, 1'b0);
            tick();
        end
        kiosk_req = 2'b11;
        #2;
        chk("wd_back_idle", busy, 1'b0);
        chk("wd_no_fault_idle", fault, 1'b0);
        tick();
        #2;
        chk("wd_rr_advanced", grant, 2'b10);
        kiosk_req = 2'b00;

        // ---- async reset during RUN ----
        do_reset();
        start_basic(2'b01);
        SPRAY = 1'b0;                    // fall seen this cycle
        tick();
        #2;
        chk("rst_pre_done", done, 1'b1);
        tick();
        start_basic(2'b11);              // pointer now at kiosk 1
        #2;
        chk("rst_pre_busy", busy, 1'b1);
        chk("rst_pre_aid", active_id, 1'b1);
        #1;
        CLR = 1'b0;
        #1;
        chk("rst_async_outputs",
            {grant, TOKEN, START, busy, done, fault, wash_abort, T1DONE, T2DONE, active_id},
            '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        CLR   = 1'b1;
        SPRAY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("rst_no_done_fault", {done, fault, busy}, 3'b000);
            tick();
        end
        kiosk_req = 2'b11;
        tick();
        #2;
        chk("rst_first_grant", grant, 2'b01);
        kiosk_req = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/carwash_bay_scheduler.md
# carwash_bay_scheduler

Shares one wash bay among `N_KIOSK` pay kiosks and sequences the bay's wash controller. Round-robin arbitration picks a waiting kiosk and replays its purchase to the controller as TOKEN/START pulses. The block owns the spray and rinse timers that the controller clears and polls, and reports completion, watchdog faults and the active kiosk.

## Interface
- `N_KIOSK`, 2: number of requesting kiosks, 2..8
- `T1_CYCLES`, 8: spray-timer expiry count
- `T2_CYCLES`, 4: rinse-timer expiry count
- `WD_CYCLES`, 64: RUN-state watchdog limit
- `clk`  in  1  clock, all state updates on rising edge
- `CLR`  in  1  reset, asynchronous, active-low
- `kiosk_req`  in  N_KIOSK  level: kiosk holds a paid customer
- `kiosk_deluxe`  in  N_KIOSK  1 = two-token wash, 0 = one-token wash; sampled at grant
- `grant`  out  N_KIOSK  one-hot, one-cycle pulse to the selected kiosk
- `TOKEN`  out  1  one-cycle token pulse to the wash controller
- `START`  out  1  one-cycle start pulse to the wash controller
- `CLRT1`, `CLRT2`  in  1  timer clears from the wash controller
- `SPRAY`, `SOAP`  in  1  wash controller outputs, monitored
- `T1DONE`, `T2DONE`  out  1  timer expiry flags to the wash controller
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a wash completes
- `active_id`  out  $clog2(N_KIOSK)  index of the granted kiosk, held until the next grant
- `fault`  out  1  one-cycle pulse on watchdog expiry
- `wash_abort`  out  1  one-cycle pulse on watchdog expiry; the controller uses it to return to its idle state

## Operation
- States: IDLE, ARB, TOK1, TOK2, STRT, RUN, DONE.
- IDLE -> ARB when any `kiosk_req` bit is set.
- ARB:
  - Scan from `rr_ptr` upward with wrap. The first set bit wins.
  - Latch `active_id` and the winner's `kiosk_deluxe` bit.
  - Pulse `grant`.
  - Go to TOK1. If all requests dropped in the same cycle, return to IDLE with no grant.
- TOK1: `TOKEN`=1. Go to TOK2 if deluxe, otherwise STRT.
- TOK2: `TOKEN`=1 (second token). Go to RUN.
- STRT: `START`=1. Go to RUN.
- RUN:
  - Count `SPRAY` falling edges (registered previous `SPRAY`).
  - Required count: basic 1, deluxe 2.
  - On reaching the required count, go to DONE.
  - The watchdog counts RUN cycles. At `WD_CYCLES`, pulse `fault` and `wash_abort` and go to IDLE with no `done`. `rr_ptr` still advances.
- DONE: pulse `done`, set `rr_ptr` = (`active_id`+1) mod N_KIOSK, go to IDLE.
- After grant, `kiosk_req` and `kiosk_deluxe` are ignored until IDLE. A kiosk still requesting is re-arbitrated normally.
- Timers (each one a `carwash_timer`):
  - `CLRT`=1 loads 0.
  - Otherwise the count increments, saturating at the limit.
  - `TxDONE` = (count == limit), registered.
  - Clear has priority over increment.
- Widths: counters are `$clog2(limit+1)` bits. No wrap is permitted.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - Outputs: `grant`=0, `TOKEN`=0, `START`=0, `busy`=0, `done`=0, `fault`=0, `wash_abort`=0, `active_id`=0.
  - Timer counts 0, so `T1DONE`=`T2DONE`=0.
- Request-to-first-TOKEN latency is 2 cycles (IDLE, ARB). Basic: TOKEN at cycle 2, START at 3. Deluxe: TOKEN at 2 and 3.
- `done` is asserted the cycle after the qualifying `SPRAY` falling edge is registered.
- At most one of TOKEN/START is high in any cycle. `grant` is never high outside ARB.
- Timer expiry: with a clear at cycle c, `TxDONE` rises at cycle c+limit+1 and holds until the next clear.
- Asynchronous reset mid-wash aborts immediately. No `done` and no `fault` are produced.

## Structure
- `carwash_pkg`: state enum `sched_state_t` and default constants for T1/T2/WD.
- Sub-module `carwash_timer` (parameter `LIMIT`; ports clk, CLR, clr_t, done), instantiated twice.

## Test plan
- Reset release, no requests, 20 cycles -> `busy`=0, all pulses 0, `T1DONE`=`T2DONE`=0.
- `kiosk_req`=01, basic; controller model gives one SPRAY burst -> `grant`=01 at cycle 1, TOKEN at cycle 2, START at cycle 3, `done` one cycle after SPRAY falls, `active_id`=0.
- `kiosk_req`=11 held, kiosk1 deluxe -> kiosk0 served first, then kiosk1. Kiosk1 gets two TOKEN pulses, and `done` follows only the second SPRAY fall.
- `CLRT1` pulse, then idle, with T1_CYCLES=8 -> `T1DONE` rises exactly 9 cycles after the clear. A second clear at expiry drops it next cycle.
- Controller model never drops SPRAY -> `fault` and `wash_abort` pulse after 64 RUN cycles, return to IDLE, `rr_ptr` advanced.
- CLR asserted during RUN -> all outputs 0 asynchronously. After release, the first grant goes to kiosk 0.
